// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor: one full-subtractor cell, LSB first, start/done handshake.
// Optional zero-result flag port enabled by defining SERIAL_SUB_ZERO_FLAG_EN.

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  half_subtractor u_hs1 (.x(x),  .y(y),   .d(d1), .b(b1));
  half_subtractor u_hs2 (.x(d1), .y(bin), .d(d),  .b(b2));

  assign bout = b1 | b2;
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  state_e           state_q, state_d;
  opnd_t            opnd_q;
  logic [WIDTH-1:0] diff_q, diff_next;
  logic [CNT_W-1:0] cnt_q;
  logic             bq, d_bit, bout;
  logic             load, shift, last;

  full_subtractor_cell u_cell (
    .x   (opnd_q.a[0]),
    .y   (opnd_q.b[0]),
    .bin (bq),
    .d   (d_bit),
    .bout(bout)
  );

  assign diff_next = {d_bit, diff_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        load    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        shift = 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers are not cleared on load; WIDTH shifts fully overwrite diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q <= '0;
      diff_q <= '0;
      bq     <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      opnd_q <= {a, b};
      bq     <= 1'b0;
      cnt_q  <= '0;
    end else if (shift) begin
      opnd_q.a <= opnd_q.a >> 1;
      opnd_q.b <= opnd_q.b >> 1;
      diff_q   <= diff_next;
      bq       <= bout;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    zero_q <= 1'b0;
    else if (last) zero_q <= (diff_next == '0);
  end

  assign zero = zero_q;
`endif

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = bq;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized + directed bench for serial_subtractor at WIDTH=8 and WIDTH=4,
// checked against plain modular arithmetic.

module tb_serial_subtractor;
  localparam int W8 = 8;
  localparam int W4 = 4;

  logic          clk, rst_n;
  logic          start, busy, done, borrow;
  logic [W8-1:0] a, b, diff;
  logic          start4, busy4, done4, borrow4;
  logic [W4-1:0] a4, b4, diff4;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic          zero, zero4;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .zero(zero4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: waits for idle, issues one op, returns the number of edges
  // from the accepting edge to the first sample where done is seen (-1 = timeout).
  task automatic run_op8(input logic [W8-1:0] av, bv, output int lat,
                         output logic [W8-1:0] d, output logic br);
    lat = -1; d = '0; br = 1'b0;
    for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W8'($urandom); b = W8'($urandom);
    for (int k = 1; k <= W8 + 4; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; d = diff; br = borrow; break; end
    end
  endtask

  task automatic run_op4(input logic [W4-1:0] av, bv, output int lat,
                         output logic [W4-1:0] d, output logic br);
    lat = -1; d = '0; br = 1'b0;
    for (int i = 0; i < 40 && (busy4 || done4); i++) @(negedge clk);
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = W4'($urandom); b4 = W4'($urandom);
    for (int k = 1; k <= W4 + 4; k++) begin
      @(posedge clk); #1;
      if (done4) begin lat = k; d = diff4; br = borrow4; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #3;
    checks++;
    if ({busy, done, diff, borrow} !== '0) begin
      errors++; $display("FAIL reset8 got busy=%b done=%b diff=%h borrow=%b want all 0", busy, done, diff, borrow);
    end
    checks++;
    if ({busy4, done4, diff4, borrow4} !== '0) begin
      errors++; $display("FAIL reset4 got busy=%b done=%b diff=%h borrow=%b want all 0", busy4, done4, diff4, borrow4);
    end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int lat; logic [W8-1:0] d; logic br;
    // done is seen after edge T+WIDTH and drops at edge T+WIDTH+1
    run_op8(8'h5A, 8'h3C, lat, d, br);
    checks++;
    if (lat !== W8) begin errors++; $display("FAIL lat_5a3c got %0d want %0d", lat, W8); end
    checks++;
    if (d !== 8'h1E || br !== 1'b0) begin errors++; $display("FAIL res_5a3c got %h/%b want 1e/0", d, br); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end

    run_op8(8'h00, 8'h01, lat, d, br);
    checks++;
    if (d !== 8'hFF || br !== 1'b1) begin errors++; $display("FAIL res_0001 got %h/%b want ff/1", d, br); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (diff !== 8'hFF || borrow !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got diff=%h borrow=%b done=%b busy=%b want ff/1/0/0", i, diff, borrow, done, busy);
      end
    end

    run_op8(8'h80, 8'h80, lat, d, br);
    checks++;
    if (d !== 8'h00 || br !== 1'b0) begin errors++; $display("FAIL res_8080 got %h/%b want 00/0", d, br); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL zero_8080 got %b want 1", zero); end
`endif
    run_op8(8'h81, 8'h80, lat, d, br);
    checks++;
    if (d !== 8'h01 || br !== 1'b0) begin errors++; $display("FAIL res_8180 got %h/%b want 01/0", d, br); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL zero_8180 got %b want 0", zero); end
`endif
  endtask

  task automatic test_ignore_start();
    int dones = 0; logic [W8-1:0] d = '0; logic br = 1'b0;
    for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b want 1", busy); end
    for (int k = 1; k <= W8 + 6; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (k == 4) start = 1'b0;
      if (done) begin dones++; d = diff; br = borrow; end
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    checks++;
    if (d !== 8'h1E || br !== 1'b0) begin errors++; $display("FAIL ignore_res got %h/%b want 1e/0", d, br); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [W8-1:0] d; logic br;
    run_op8(8'h00, 8'h01, lat, d, br);   // leave nonzero diff/borrow behind
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow} !== '0) begin
      errors++; $display("FAIL async_reset got busy=%b done=%b diff=%h borrow=%b want all 0", busy, done, diff, borrow);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < W8 + 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL aborted_run got done=%b busy=%b want 0/0", done, busy); end
    end
    run_op8(8'h10, 8'h20, lat, d, br);
    checks++;
    if (d !== 8'hF0 || br !== 1'b1) begin errors++; $display("FAIL res_after_reset got %h/%b want f0/1", d, br); end
  endtask

  task automatic test_width4();
    int lat; logic [W4-1:0] d; logic br;
    run_op4(4'h3, 4'h7, lat, d, br);
    checks++;
    if (lat !== W4) begin errors++; $display("FAIL lat_w4 got %0d want %0d", lat, W4); end
    checks++;
    if (d !== 4'hC || br !== 1'b1) begin errors++; $display("FAIL res_w4 got %h/%b want c/1", d, br); end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
    @(negedge clk);
    a = 8'hC3; b = 8'h3C; start = 1'b1;
    for (int k = 0; k <= 3 * W8 && second < 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = k; else second = k;
        checks++;
        if (diff !== 8'h87 || borrow !== 1'b0) begin errors++; $display("FAIL b2b_res got %h/%b want 87/0", diff, borrow); end
      end
    end
    start = 1'b0;
    checks++;
    if (first !== W8 || second !== 2 * W8 + 2) begin
      errors++; $display("FAIL b2b_timing got %0d,%0d want %0d,%0d", first, second, W8, 2 * W8 + 2);
    end
  endtask

  task automatic test_random();
    int lat; logic [W8-1:0] d, av, bv; logic br;
    logic [W4-1:0] d4, av4, bv4;
    for (int n = 0; n < 25; n++) begin
      av = W8'($urandom); bv = W8'($urandom);
      if (n % 8 == 0) bv = av;
      run_op8(av, bv, lat, d, br);
      checks++;
      if (lat !== W8 || d !== W8'(av - bv) || br !== (av < bv)) begin
        errors++; $display("FAIL rand8 %h-%h got lat=%0d %h/%b want lat=%0d %h/%b", av, bv, lat, d, br, W8, W8'(av - bv), av < bv);
      end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      checks++;
      if (zero !== (av == bv)) begin errors++; $display("FAIL rand8_zero got %b want %b", zero, av == bv); end
`endif
    end
    for (int n = 0; n < 12; n++) begin
      av4 = W4'($urandom); bv4 = W4'($urandom);
      run_op4(av4, bv4, lat, d4, br);
      checks++;
      if (lat !== W4 || d4 !== W4'(av4 - bv4) || br !== (av4 < bv4)) begin
        errors++; $display("FAIL rand4 %h-%h got lat=%0d %h/%b want lat=%0d %h/%b", av4, bv4, lat, d4, br, W4, W4'(av4 - bv4), av4 < bv4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_width4();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
